// File: rtl/qei_pkg.sv
// Shared step encoding and quadrature decode helper for the QEI slice.
package qei_pkg;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_FWD  = 2'd1,
      STEP_REV  = 2'd2,
      STEP_ERR  = 2'd3
   } step_t;

   typedef enum logic {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } prime_state_t;

   localparam logic [7:0] ERR_MAX = 8'd255;

   // Position of {A,B} around the forward cycle 00->10->11->01.
   function automatic logic [1:0] phase_of(input logic [1:0] ab);
      logic [1:0] ph;
      case (ab)
         2'b00:   ph = 2'd0;
         2'b10:   ph = 2'd1;
         2'b11:   ph = 2'd2;
         default: ph = 2'd3;
      endcase
      return ph;
   endfunction

   function automatic step_t decode(input logic [1:0] prev, input logic [1:0] curr);
      logic [1:0] d;
      step_t      s;
      d = phase_of(curr) - phase_of(prev);
      case (d)
         2'd1:    s = STEP_FWD;
         2'd3:    s = STEP_REV;
         2'd2:    s = STEP_ERR;
         default: s = STEP_NONE;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/qei_filter.sv
// One encoder channel: 2-flop synchronizer followed by a FILT_LEN stability filter.
module qei_filter #(
   parameter int FILT_LEN = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic filtered,
   output logic settled
);

   localparam int CNT_W = $clog2(FILT_LEN + 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         cnt      <= '0;
         filtered <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == filtered) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
            filtered <= sync2;
            cnt      <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign settled = (sync2 == filtered);

endmodule

// File: rtl/qei_decoder.sv
// Quadrature encoder interface for one axis: filtering, 4x decode, position,
// windowed velocity and illegal-transition statistics.
module qei_decoder #(
   parameter int COUNT_W    = 32,
   parameter int FILT_LEN   = 4,
   parameter int VEL_PERIOD = 50000,
   parameter int VEL_W      = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         encab,
   input  logic               clear,
   output logic [COUNT_W-1:0] position,
   output logic [VEL_W-1:0]   velocity,
   output logic               vel_valid,
   output logic               dir,
   output logic [7:0]         err_count
);

   import qei_pkg::*;

   localparam int PC_W  = $clog2(FILT_LEN + 1);
   localparam int WIN_W = $clog2(VEL_PERIOD);
   localparam logic [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W - 1){1'b1}}};
   localparam logic [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W - 1){1'b0}}};

   logic [1:0]       filt_ab;
   logic [1:0]       settled;
   logic [1:0]       prev;
   logic [PC_W-1:0]  prime_cnt;
   logic [WIN_W-1:0] win_cnt;
   logic [VEL_W-1:0] acc;
   logic             both_settled;
   logic             primed;
   step_t            step;
   prime_state_t     state;
   prime_state_t     state_next;

   qei_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
      .clk      (clk),
      .reset    (reset),
      .raw      (encab[1]),
      .filtered (filt_ab[1]),
      .settled  (settled[1])
   );

   qei_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
      .clk      (clk),
      .reset    (reset),
      .raw      (encab[0]),
      .filtered (filt_ab[0]),
      .settled  (settled[0])
   );

   assign both_settled = &settled;

   function automatic logic [VEL_W-1:0] sat_step(input logic [VEL_W-1:0] v, input step_t s);
      logic [VEL_W-1:0] r;
      r = v;
      if (s == STEP_FWD && v != VEL_MAX) begin
         r = v + VEL_W'(1);
      end else if (s == STEP_REV && v != VEL_MIN) begin
         r = v - VEL_W'(1);
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_PRIME;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (state == ST_PRIME && both_settled && prime_cnt == PC_W'(FILT_LEN - 1)) begin
         state_next = ST_RUN;
      end
   end

   always_comb begin
      primed = (state == ST_RUN);
      step   = STEP_NONE;
      if (primed) begin
         step = decode(prev, filt_ab);
      end
   end

   // Prime only once both channels have agreed with their sync inputs for FILT_LEN cycles.
   always_ff @(posedge clk) begin
      if (reset || !both_settled) begin
         prime_cnt <= '0;
      end else if (state == ST_PRIME) begin
         prime_cnt <= prime_cnt + PC_W'(1);
      end
   end

   // prev tracks filtered every cycle; decode is gated by primed, so the prime edge
   // loads the reference without producing a step.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev <= 2'b00;
      end else begin
         prev <= filt_ab;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         position  <= '0;
         dir       <= 1'b0;
         err_count <= '0;
      end else begin
         if (clear) begin
            position <= '0;
         end else if (step == STEP_FWD) begin
            position <= position + COUNT_W'(1);
         end else if (step == STEP_REV) begin
            position <= position - COUNT_W'(1);
         end
         if (step == STEP_FWD) begin
            dir <= 1'b1;
         end else if (step == STEP_REV) begin
            dir <= 1'b0;
         end
         if (step == STEP_ERR && err_count != ERR_MAX) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         win_cnt   <= WIN_W'(VEL_PERIOD - 1);
         acc       <= '0;
         velocity  <= '0;
         vel_valid <= 1'b0;
      end else if (win_cnt == '0) begin
         win_cnt   <= WIN_W'(VEL_PERIOD - 1);
         velocity  <= sat_step(acc, step);
         acc       <= '0;
         vel_valid <= 1'b1;
      end else begin
         win_cnt   <= win_cnt - WIN_W'(1);
         acc       <= sat_step(acc, step);
         vel_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_qei_decoder.sv
// Bench for qei_decoder: directed vector table, hand-written corner sequences and
// random motion checked every cycle against a history-window reference model.
module tb_qei_decoder;

   localparam int F  = 4;
   localparam int VP = 100;
   localparam int CW = 32;
   localparam int VW = 16;

   typedef struct {
      bit          rst;
      logic [1:0]  ab;
      int          hold;
      logic [31:0] pos;
      logic        dir;
      logic [7:0]  err;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          clear;
   logic [1:0]    encab;
   logic [CW-1:0] position;
   logic [VW-1:0] velocity;
   logic          vel_valid;
   logic          dir;
   logic [7:0]    err_count;

   int checks = 0;
   int errors = 0;
   bit model_on = 0;
   int vv_seen = 0;

   vec_t vecs [16];

   always #5 clk = ~clk;

   qei_decoder #(
      .COUNT_W    (CW),
      .FILT_LEN   (F),
      .VEL_PERIOD (VP),
      .VEL_W      (VW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .encab     (encab),
      .clear     (clear),
      .position  (position),
      .velocity  (velocity),
      .vel_valid (vel_valid),
      .dir       (dir),
      .err_count (err_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd_next(input logic [1:0] ab);
      case (ab)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] rev_next(input logic [1:0] ab);
      case (ab)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic int clamp(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Reference model: a channel flips once its last F raw samples (delayed two edges by
   // the synchronizer) all disagree with it; counts follow the forward/reverse successor tables.
   logic [1:0]  hq [0:F];
   logic [1:0]  m_filt, m_prev, nf;
   logic [31:0] m_pos;
   logic        m_dir, m_vv;
   bit          m_primed, flip, is_err;
   int          m_s, m_acc, m_vel, m_err, st;

   always @(posedge clk) begin
      if (reset) begin
         m_s = 0; m_primed = 0; m_filt = '0; m_prev = '0; m_pos = '0;
         m_dir = 0; m_err = 0; m_acc = 0; m_vel = 0; m_vv = 0;
         for (int i = 0; i <= F; i++) hq[i] = '0;
      end else begin
         m_s++;
         for (int c = 0; c < 2; c++) begin
            flip = 1;
            for (int i = 0; i < F; i++) if (hq[i][c] == m_filt[c]) flip = 0;
            nf[c] = flip ? ~m_filt[c] : m_filt[c];
         end
         st = 0;
         is_err = 0;
         if (m_primed) begin
            if (m_filt == fwd_next(m_prev)) st = 1;
            else if (m_filt == rev_next(m_prev)) st = -1;
            else if (m_filt != m_prev) is_err = 1;
         end else if (m_s == F) begin
            m_primed = 1;
         end
         m_prev = m_filt;
         m_pos = clear ? 32'h0 : m_pos + 32'(st);
         if (st == 1) m_dir = 1;
         if (st == -1) m_dir = 0;
         if (is_err && m_err < 255) m_err++;
         m_vv = (m_s % VP == 0);
         if (m_vv) begin
            m_vel = clamp(m_acc + st);
            m_acc = 0;
         end else begin
            m_acc = clamp(m_acc + st);
         end
         m_filt = nf;
         for (int i = 0; i < F; i++) hq[i] = hq[i + 1];
         hq[F] = encab;
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("model_position", 64'(position), 64'(m_pos));
         check("model_velocity", 64'($signed(velocity)), 64'(m_vel));
         check("model_vel_valid", 64'(vel_valid), 64'(m_vv));
         check("model_dir", 64'(dir), 64'(m_dir));
         check("model_err_count", 64'(err_count), 64'(m_err));
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      clear = 1'b1;
      encab = 2'b00;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_s(input int k);
      int guard;
      guard = 0;
      while (m_s < k) begin
         @(negedge clk);
         if (vel_valid) vv_seen++;
         guard++;
         if (guard > k + 20) begin
            check("wait_s_timeout", 64'(m_s), 64'(k));
            return;
         end
      end
   endtask

   task automatic hold_ab(input logic [1:0] ab, input int n);
      encab = ab;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] ab;
      int r;
      int hold;
      bit saw_one;

      reset = 1'b1;
      clear = 1'b0;
      encab = 2'b00;
      vecs = '{
         '{1'b1, 2'b00, 10, 32'h0000_0000, 1'b0, 8'd0},
         '{1'b0, 2'b10, 20, 32'h0000_0001, 1'b1, 8'd0},
         '{1'b0, 2'b11, 20, 32'h0000_0002, 1'b1, 8'd0},
         '{1'b0, 2'b01, 20, 32'h0000_0003, 1'b1, 8'd0},
         '{1'b0, 2'b00, 20, 32'h0000_0004, 1'b1, 8'd0},
         '{1'b0, 2'b10, 20, 32'h0000_0005, 1'b1, 8'd0},
         '{1'b0, 2'b11, 20, 32'h0000_0006, 1'b1, 8'd0},
         '{1'b0, 2'b01, 20, 32'h0000_0007, 1'b1, 8'd0},
         '{1'b0, 2'b00, 20, 32'h0000_0008, 1'b1, 8'd0},
         '{1'b1, 2'b00, 10, 32'h0000_0000, 1'b0, 8'd0},
         '{1'b0, 2'b01, 20, 32'hFFFF_FFFF, 1'b0, 8'd0},
         '{1'b0, 2'b11, 20, 32'hFFFF_FFFE, 1'b0, 8'd0},
         '{1'b0, 2'b10, 20, 32'hFFFF_FFFD, 1'b0, 8'd0},
         '{1'b0, 2'b11, 20, 32'hFFFF_FFFE, 1'b1, 8'd0},
         '{1'b0, 2'b01, 20, 32'hFFFF_FFFF, 1'b1, 8'd0},
         '{1'b0, 2'b00, 20, 32'h0000_0000, 1'b1, 8'd0}
      };

      @(negedge clk);
      model_on = 1;
      check("reset_position", 64'(position), 64'h0);
      check("reset_velocity", 64'(velocity), 64'h0);
      check("reset_vel_valid", 64'(vel_valid), 64'h0);
      check("reset_dir", 64'(dir), 64'h0);
      check("reset_err_count", 64'(err_count), 64'h0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         hold_ab(vecs[i].ab, vecs[i].hold);
         check($sformatf("vec%0d_position", i), 64'(position), 64'(vecs[i].pos));
         check($sformatf("vec%0d_dir", i), 64'(dir), 64'(vecs[i].dir));
         check($sformatf("vec%0d_err", i), 64'(err_count), 64'(vecs[i].err));
      end

      // Latency: step must land on the seventh edge after the input change.
      hold_ab(2'b10, F + 2);
      check("latency_before", 64'(position), 64'h0);
      @(negedge clk);
      check("latency_at", 64'(position), 64'h1);
      hold_ab(2'b10, 20);
      hold_ab(2'b00, 20);
      check("glitch_base", 64'(position), 64'h0);

      hold_ab(2'b10, F - 1);
      hold_ab(2'b00, 20);
      check("glitch3_position", 64'(position), 64'h0);
      check("glitch3_err", 64'(err_count), 64'h0);
      saw_one = 0;
      hold_ab(2'b10, F);
      encab = 2'b00;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (position == 32'h1) saw_one = 1;
      end
      check("glitch4_saw_plus1", 64'(saw_one), 64'h1);
      check("glitch4_position", 64'(position), 64'h0);

      do_reset();
      hold_ab(2'b00, 10);
      hold_ab(2'b11, 10);
      check("illegal_err1", 64'(err_count), 64'd1);
      check("illegal_pos1", 64'(position), 64'h0);
      for (int i = 1; i < 300; i++) hold_ab(~encab, 10);
      check("illegal_err_sat", 64'(err_count), 64'd255);
      check("illegal_pos_sat", 64'(position), 64'h0);

      do_reset();
      hold_ab(2'b00, 10);
      hold_ab(2'b10, 20);
      hold_ab(2'b11, 20);
      hold_ab(2'b01, F + 2);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear_position", 64'(position), 64'h0);
      check("clear_dir", 64'(dir), 64'h1);
      hold_ab(2'b01, 10);
      check("clear_hold", 64'(position), 64'h0);

      do_reset();
      wait_s(VP);
      check("win1_valid", 64'(vel_valid), 64'h1);
      check("win1_velocity", 64'(velocity), 64'h0);
      vv_seen = 0;
      ab = 2'b00;
      for (int k = 0; k < 10; k++) begin
         wait_s(112 + 9 * k);
         ab = fwd_next(ab);
         encab = ab;
      end
      wait_s(2 * VP);
      check("win2_valid", 64'(vel_valid), 64'h1);
      check("win2_velocity", 64'(velocity), 64'd10);
      check("win2_pulses", 64'(vv_seen), 64'd1);
      check("win2_position", 64'(position), 64'd10);
      wait_s(3 * VP);
      check("win3_velocity", 64'(velocity), 64'h0);
      check("win3_valid", 64'(vel_valid), 64'h1);
      wait_s(350);
      do_reset();
      wait_s(VP - 1);
      check("rst_win_quiet_valid", 64'(vel_valid), 64'h0);
      check("rst_win_quiet_vel", 64'(velocity), 64'h0);
      wait_s(VP);
      check("rst_win_valid", 64'(vel_valid), 64'h1);
      check("rst_win_vel", 64'(velocity), 64'h0);

      do_reset();
      hold_ab(2'b00, 10);
      ab = 2'b00;
      for (int n = 0; n < 500; n++) begin
         r = $urandom_range(0, 99);
         hold = $urandom_range(1, 12);
         if (r < 2) begin
            do_reset();
            ab = 2'b00;
            hold = 8;
         end else if (r < 45) ab = fwd_next(ab);
         else if (r < 80) ab = rev_next(ab);
         else if (r < 88) ab = ~ab;
         encab = ab;
         if ($urandom_range(0, 19) == 0) begin
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
         end
         repeat (hold) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/qei_decoder.md
Name: qei_decoder

Overview:
- Quadrature encoder interface for one servo axis; consumes raw encoder A/B pins from GPIO (GPIO_x[7:6]) and produces signed position, windowed velocity and error statistics for the system bus slave.
- Contains a per-channel synchronizer, a glitch filter, a 4x quadrature decoder, a position counter and a fixed-window velocity sampler.
- One instance per axis; two per board.

Parameters:
- COUNT_W, 32, position counter width (two's complement, wraps).
- FILT_LEN, 4, consecutive stable cycles required before a filtered channel changes (>=1).
- VEL_PERIOD, 50000, velocity window length in clk cycles (1 kHz at 50 MHz; >=2).
- VEL_W, 16, velocity output width (signed, saturating).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- encab  in  2  raw encoder inputs, asynchronous; encab[1]=A, encab[0]=B.
- clear  in  1  synchronous position clear, single-cycle strobe.
- position  out  COUNT_W  signed accumulated step count.
- velocity  out  VEL_W  signed steps counted in the last complete window.
- vel_valid  out  1  one-cycle pulse when velocity updates.
- dir  out  1  direction of the last valid step (1 = forward).
- err_count  out  8  illegal transitions seen, saturates at 255.

Behaviour:
- Reset (clk edge with reset=1): position=0, velocity=0, vel_valid=0, dir=0, err_count=0; synchronizers, filters and window counter cleared; primed=0.
- Synchronizer: 2 flops per channel. Raw change stable before edge E0 is visible at the sync2 output after edge E1.
- Filter, per channel: a counter increments while sync2 != filtered and resets to 0 when they are equal.
  - filtered takes the sync2 value on the edge where sync2 has differed for FILT_LEN consecutive sampled cycles, i.e. edge E1+FILT_LEN.
  - Pulses shorter than FILT_LEN cycles at sync2 are rejected entirely.
- Priming: after reset, the first edge on which both filter counters reach FILT_LEN (or FILT_LEN cycles after reset with inputs stable) loads prev={A,B} with no count and no error, then sets primed=1.
  - Until primed=1, no steps and no errors are produced.
- Decoder: compares filtered {A,B} against prev each cycle; prev updates every cycle.
  - Forward (+1) sequence: 00→10→11→01→00.
  - Reverse (-1) is the opposite order.
  - No change: 0.
  - Both bits changed: illegal; step 0, err_count+1 (saturating at 255), dir unchanged.
- Position: updates on edge E0+FILT_LEN+2 for a clean input edge. Arithmetic is modulo 2^COUNT_W (0xFFFFFFFF+1 → 0, 0-1 → 0xFFFFFFFF).
  - dir is updated with each valid step.
- clear: position=0 on the next edge. A step in that same cycle is discarded for position but still counts toward velocity and updates dir.
- Velocity window: down-counter loaded with VEL_PERIOD-1 at reset, decremented every cycle.
  - acc accumulates steps, saturating at the VEL_W signed limits.
  - On the edge where the counter is 0: velocity = sat(acc + step_this_cycle), acc = 0, counter reloads, vel_valid=1 for exactly that cycle.
  - First vel_valid occurs VEL_PERIOD cycles after reset is released.
- Reset mid-operation: all state returns to reset values on that edge. Motion during reset is not counted; priming repeats.
- clear and reset both asserted: reset wins.

Decomposition:
- Shared package qei_pkg:
  - step encoding constants: STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR (2-bit);
  - decode function (prev, curr) → step;
  - ERR_MAX=255.
- Sub-module qei_filter: one channel's 2-flop synchronizer plus FILT_LEN stability counter, parameter FILT_LEN; instantiated twice.
- The top level holds priming, decode, position, velocity and error logic.

Test Plan:
- Forward rotation: after priming at 00, drive 8 forward steps (00,10,11,01,...), each held 20 cycles → position=8, dir=1, err_count=0. First update lands exactly FILT_LEN+2 edges after the input change.
- Reverse from 0: 3 reverse steps → position=0xFFFFFFFD, dir=0. Then preload by stepping to position=0xFFFFFFFF and step forward once → position=0.
- Glitch rejection (FILT_LEN=4): A pulses high for 3 cycles → no position or error change. A 4-cycle pulse → +1 then -1; position returns to original.
- Illegal jump 00→11 held 10 cycles → err_count=1, position unchanged. Repeat 300 times → err_count=255.
- clear asserted in the same cycle a forward step registers → position=0 next cycle. That window's velocity still includes the step.
- Velocity (VEL_PERIOD=100): 10 forward steps inside one window, including one landing in the window's last cycle → vel_valid pulses once with velocity=10. Next idle window → velocity=0. Reset asserted mid-window → window restarts; velocity=0 until the next full window.
